// File: rtl/bf_program_loader.sv
// bf_program_loader: encodes a streamed Brainfuck source into 4-bit opcodes in program memory; BF_LOADER_STRICT_EN rejects stray characters
module bf_program_loader #(
    parameter int AW = 8,
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ch_valid,
    input  logic [7:0]    ch_data,
    output logic          ch_ready,
    output logic [AW-1:0] PAddr,
    output logic [3:0]    PData,
    output logic          PWe,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [2:0]    err_code,
    output logic [AW:0]   prog_len
);
    localparam logic [2:0] IDLE = 3'd0, ACCEPT = 3'd1, WRITE = 3'd2, TERM = 3'd3, DONE = 3'd4, ERR = 3'd5;
    logic [2:0]    state;
    logic [AW-1:0] waddr;
    logic [DW-1:0] depth;
    logic [7:0]    ch_q;
    logic [2:0]    op, wr_err, err_now;
    logic          is_cmd, is_term, is_open, is_close, stray, wr_ok;
    // decode the captured character and resolve which abort, if any, it triggers
    always_comb begin
        op = 3'd0;
        is_cmd = 1'b1;
        case (ch_q)
            8'h3C: op = 3'd0;
            8'h3E: op = 3'd1;
            8'h2B: op = 3'd2;
            8'h2D: op = 3'd3;
            8'h5B: op = 3'd4;
            8'h5D: op = 3'd5;
            8'h2E: op = 3'd6;
            8'h2C: op = 3'd7;
            default: is_cmd = 1'b0;
        endcase
        is_term = ch_q == 8'h00 || ch_q == 8'h21;
        is_open = ch_q == 8'h5B;
        is_close = ch_q == 8'h5D;
`ifdef BF_LOADER_STRICT_EN
        stray = !is_cmd && !is_term && !(ch_q == 8'h20 || ch_q == 8'h0D || ch_q == 8'h0A);
`else
        stray = 1'b0;
`endif
        wr_err = (is_close && depth == '0) ? 3'd1 : (&waddr) ? 3'd3 : (is_open && &depth) ? 3'd4 : 3'd0;
        err_now = is_cmd ? wr_err : stray ? 3'd5 : 3'd0;
        wr_ok = state == WRITE && is_cmd && err_now == 3'd0;
    end
    assign ch_ready = state == ACCEPT;
    assign busy     = state == ACCEPT || state == WRITE || state == TERM;
    assign done     = state == DONE;
    assign error    = state == ERR;
    assign PWe      = wr_ok || (state == TERM && depth == '0);
    assign PAddr    = waddr;
    assign PData    = !PWe ? 4'h0 : state == TERM ? 4'hF : {1'b0, op};
    // load sequencing: accept, decode/write, then terminate with stop or abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            waddr <= '0;
            depth <= '0;
            ch_q <= 8'h00;
            err_code <= 3'd0;
            prog_len <= '0;
        end else if (start && !busy) begin
            state <= ACCEPT;
            waddr <= '0;
            depth <= '0;
            err_code <= 3'd0;
            prog_len <= '0;
        end else begin
            case (state)
                ACCEPT: if (ch_valid) begin
                    ch_q <= ch_data;
                    state <= WRITE;
                end
                WRITE: if (is_term) begin
                    state <= TERM;
                end else if (err_now != 3'd0) begin
                    err_code <= err_now;
                    state <= ERR;
                end else begin
                    state <= ACCEPT;
                    if (wr_ok) waddr <= waddr + 1'b1;
                    if (wr_ok && is_open) depth <= depth + 1'b1;
                    else if (wr_ok && is_close) depth <= depth - 1'b1;
                end
                TERM: if (depth == '0) begin
                    prog_len <= {1'b0, waddr} + 1'b1;
                    state <= DONE;
                end else begin
                    err_code <= 3'd2;
                    state <= ERR;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bf_program_loader.sv
// tb_bf_program_loader: randomized and directed loads of two loaders (AW=8 and AW=2) against a behavioural model
module tb_bf_program_loader;
    typedef byte bq_t[$];
    logic clk = 0, reset = 0, start = 0, ch_valid = 0, cur = 0;
    logic [7:0] ch_data = 0;
    logic r0, we0, b0, dn0, e0, r1, we1, b1, dn1, e1;
    logic [7:0] a0;
    logic [1:0] a1;
    logic [3:0] d0, d1;
    logic [2:0] ec0, ec1, pl1;
    logic [8:0] pl0;
    int checks = 0, errors = 0;
    int wa[2][$], wd[2][$];
    int exp_w[$];
    int exp_code, exp_len;

    bf_program_loader #(.AW(8), .DW(6)) dut0 (.clk(clk), .reset(reset), .start(start & ~cur),
        .ch_valid(ch_valid & ~cur), .ch_data(ch_data), .ch_ready(r0), .PAddr(a0), .PData(d0), .PWe(we0),
        .busy(b0), .done(dn0), .error(e0), .err_code(ec0), .prog_len(pl0));
    bf_program_loader #(.AW(2), .DW(6)) dut1 (.clk(clk), .reset(reset), .start(start & cur),
        .ch_valid(ch_valid & cur), .ch_data(ch_data), .ch_ready(r1), .PAddr(a1), .PData(d1), .PWe(we1),
        .busy(b1), .done(dn1), .error(e1), .err_code(ec1), .prog_len(pl1));

    always #5 clk = ~clk;

    // memory write log per loader
    always @(posedge clk) begin
        if (we0) begin wa[0].push_back(int'(a0)); wd[0].push_back(int'(d0)); end
        if (we1) begin wa[1].push_back(int'(a1)); wd[1].push_back(int'(d1)); end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic rdy(); return cur ? r1 : r0; endfunction
    function automatic logic bsy(); return cur ? b1 : b0; endfunction
    function automatic logic dn(); return cur ? dn1 : dn0; endfunction
    function automatic logic er(); return cur ? e1 : e0; endfunction
    function automatic int ec_o(); return cur ? int'(ec1) : int'(ec0); endfunction
    function automatic int pl_o(); return cur ? int'(pl1) : int'(pl0); endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic model(input bq_t s, input int aw);
        string cmds = "<>+-[].,";
        int d, op;
        byte c;
        d = 0; exp_w = {}; exp_code = 0; exp_len = 0;
        foreach (s[k]) begin
            c = s[k];
            op = -1;
            for (int i = 0; i < 8; i++) if (cmds[i] == c) op = i;
            if (c == 8'h00 || c == 8'h21) begin
                if (d != 0) exp_code = 2;
                else begin exp_w.push_back(15); exp_len = exp_w.size(); end
                return;
            end
            if (op < 0) begin
`ifdef BF_LOADER_STRICT_EN
                if (!(c == 8'h20 || c == 8'h0D || c == 8'h0A)) begin exp_code = 5; return; end
`endif
                continue;
            end
            if (op == 5 && d == 0) begin exp_code = 1; return; end
            if (exp_w.size() == (1 << aw) - 1) begin exp_code = 3; return; end
            if (op == 4 && d == 63) begin exp_code = 4; return; end
            exp_w.push_back(op);
            d += op == 4 ? 1 : op == 5 ? -1 : 0;
        end
    endtask

    task automatic run_load(input bq_t s, input bit rnd, input bit sp, output int base);
        int i, cyc;
        logic v;
        i = 0; cyc = 0;
        base = wa[cur].size();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        while (i < s.size() && bsy() && cyc < 2000) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ch_valid = v;
            ch_data = v ? s[i] : 8'($urandom);
            start = sp && $urandom_range(0, 3) == 0;
            if (v && rdy()) i++;
            @(negedge clk); cyc++;
        end
        ch_valid = 0; start = 0;
        while (bsy() && cyc < 2000) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc >= 2000) begin errors++; $display("FAIL load timeout: got %0d cycles required < 2000", cyc); end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({r0, we0, b0, dn0, e0, a0, d0, ec0, pl0} !== '0 || {r1, we1, b1, dn1, e1, a1, d1, ec1, pl1} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h / %h required 0", {r0, we0, b0, dn0, e0, a0, d0, ec0, pl0}, {r1, we1, b1, dn1, e1, a1, d1, ec1, pl1});
        end
        @(negedge clk); reset = 1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({b0, r0, b1, r1, we0, we1} !== '0) begin errors++; $display("FAIL reset idle: got %b required 000000", {b0, r0, b1, r1, we0, we1}); end
    endtask

    task automatic test_directed();
        string dstr[10] = '{"+[->+<]!", "a+ b.!", "]+!", "[[+]!", "+++!", "++++!", "", "", "+++", "x+\015\n.!"};
        int dsel[10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
        for (int t = 0; t < 10; t++) begin
            bq_t s;
            int base, n;
            s = str2q(dstr[t]);
            if (t == 6 || t == 8) s.push_back(8'h00);
            if (t == 7) begin for (int k = 0; k < 64; k++) s.push_back(8'h5B); s.push_back(8'h21); end
            cur = dsel[t] != 0;
            model(s, cur ? 2 : 8);
            run_load(s, 0, 0, base);
            n = wa[cur].size() - base;
            checks++;
            if (n !== exp_w.size()) begin errors++; $display("FAIL dir%0d write count: got %0d required %0d", t, n, exp_w.size()); end
            for (int k = 0; k < n && k < exp_w.size(); k++) begin
                checks++;
                if (wa[cur][base+k] !== k || wd[cur][base+k] !== exp_w[k]) begin
                    errors++;
                    $display("FAIL dir%0d word %0d: got addr %0d data %0h required addr %0d data %0h", t, k, wa[cur][base+k], wd[cur][base+k], k, exp_w[k]);
                end
            end
            checks++;
            if (dn() !== (exp_code == 0) || er() !== (exp_code != 0) || ec_o() !== exp_code || (exp_code == 0 && pl_o() !== exp_len)) begin
                errors++;
                $display("FAIL dir%0d status: got done %b error %b code %0d len %0d required code %0d len %0d", t, dn(), er(), ec_o(), pl_o(), exp_code, exp_len);
            end
        end
    endtask

    task automatic test_random();
        string pool = "<>+-[[]].,x ";
        for (int it = 0; it < 24; it++) begin
            bq_t s;
            int base, n, len;
            s = {};
            cur = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 10);
            for (int k = 0; k < len; k++) s.push_back(pool[$urandom_range(0, 11)]);
            s.push_back($urandom_range(0, 1) ? 8'h21 : 8'h00);
            model(s, cur ? 2 : 8);
            run_load(s, 1, 1, base);
            n = wa[cur].size() - base;
            checks++;
            if (n !== exp_w.size()) begin errors++; $display("FAIL rnd%0d write count: got %0d required %0d", it, n, exp_w.size()); end
            for (int k = 0; k < n && k < exp_w.size(); k++) begin
                checks++;
                if (wa[cur][base+k] !== k || wd[cur][base+k] !== exp_w[k]) begin
                    errors++;
                    $display("FAIL rnd%0d word %0d: got addr %0d data %0h required addr %0d data %0h", it, k, wa[cur][base+k], wd[cur][base+k], k, exp_w[k]);
                end
            end
            checks++;
            if (dn() !== (exp_code == 0) || er() !== (exp_code != 0) || ec_o() !== exp_code || (exp_code == 0 && pl_o() !== exp_len)) begin
                errors++;
                $display("FAIL rnd%0d status: got done %b error %b code %0d len %0d required code %0d len %0d", it, dn(), er(), ec_o(), pl_o(), exp_code, exp_len);
            end
        end
    endtask

    task automatic test_back_to_back();
        string body = "+-<>.,";
        bq_t s;
        int b1_, b2_, n1, n2;
        cur = 0;
        s = {8'h5B};
        for (int k = 0; k < 8; k++) s.push_back(body[$urandom_range(0, 5)]);
        s.push_back(8'h5D);
        s.push_back(8'h2B);
        s.push_back(8'h21);
        model(s, 8);
        run_load(s, 0, 0, b1_);
        n1 = wa[0].size() - b1_;
        run_load(s, 1, 1, b2_);
        n2 = wa[0].size() - b2_;
        checks++;
        if (n1 !== exp_w.size() || n2 !== exp_w.size()) begin
            errors++;
            $display("FAIL b2b write count: got %0d and %0d required %0d", n1, n2, exp_w.size());
        end
        for (int k = 0; k < n1 && k < n2 && k < exp_w.size(); k++) begin
            checks++;
            if (wa[0][b2_+k] !== k || wd[0][b2_+k] !== wd[0][b1_+k] || wd[0][b1_+k] !== exp_w[k]) begin
                errors++;
                $display("FAIL b2b word %0d: got %0h (b2b) %0h (random) at addr %0d required %0h", k, wd[0][b1_+k], wd[0][b2_+k], wa[0][b2_+k], exp_w[k]);
            end
        end
        checks++;
        if (dn0 !== 1'b1 || e0 !== 1'b0 || int'(pl0) !== exp_len) begin
            errors++;
            $display("FAIL b2b status: got done %b error %b len %0d required done 1 error 0 len %0d", dn0, e0, pl0, exp_len);
        end
    endtask

    task automatic test_reset_mid();
        bq_t s;
        int base, n;
        cur = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; ch_valid = 1; ch_data = 8'h2B;
        @(negedge clk); ch_valid = 0;
        checks++;
        if (we0 !== 1'b1 || d0 !== 4'h2) begin errors++; $display("FAIL mid write cycle: got we %b data %h required we 1 data 2", we0, d0); end
        #2 reset = 0;
        #1;
        checks++;
        if ({r0, we0, b0, dn0, e0, a0, d0, ec0, pl0} !== '0) begin
            errors++;
            $display("FAIL mid async reset: got %h required 0", {r0, we0, b0, dn0, e0, a0, d0, ec0, pl0});
        end
        #1 reset = 1;
        @(negedge clk);
        checks++;
        if (b0 !== 1'b0 || r0 !== 1'b0) begin errors++; $display("FAIL mid idle: got busy %b ready %b required 0 0", b0, r0); end
        s = str2q("-!");
        model(s, 8);
        run_load(s, 0, 0, base);
        n = wa[0].size() - base;
        checks++;
        if (n !== exp_w.size()) begin errors++; $display("FAIL mid write count: got %0d required %0d", n, exp_w.size()); end
        for (int k = 0; k < n && k < exp_w.size(); k++) begin
            checks++;
            if (wa[0][base+k] !== k || wd[0][base+k] !== exp_w[k]) begin
                errors++;
                $display("FAIL mid word %0d: got addr %0d data %0h required addr %0d data %0h", k, wa[0][base+k], wd[0][base+k], k, exp_w[k]);
            end
        end
        checks++;
        if (dn0 !== 1'b1 || e0 !== 1'b0 || int'(pl0) !== exp_len) begin
            errors++;
            $display("FAIL mid status: got done %b error %b len %0d required done 1 error 0 len %0d", dn0, e0, pl0, exp_len);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
